lineclear_sequencer: RTL and testbench

Control block that sequences the lineclear evaluator once per locked piece. It accepts a merged 20x10 board from the lock logic, pulses the evaluator's start, and waits for completion with a watchdog. It then writes back the cleared board, updates the line, level and gravity counters, checks for top-out, and hands off to the piece spawner.

---
 rtl/lineclear_sequencer_if.sv | 34 +++
 rtl/lineclear_sequencer.sv | 169 ++++++++++++++++
 tb/tb_lineclear_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lineclear_sequencer_if.sv
// Signal bundle between the lineclear sequencer and the lock logic, the
// lineclear evaluator and the piece spawner.
interface lineclear_sequencer_if;
    logic         lock_valid;
    logic         lock_ready;
    logic [199:0] board_in;
    logic         lc_start;
    logic [199:0] lc_input;
    logic [199:0] lc_output;
    logic         lc_done;
    logic [199:0] board_out;
    logic [15:0]  lines_total;
    logic [2:0]   lines_last;
    logic [3:0]   level;
    logic [5:0]   drop_interval;
    logic         spawn_valid;
    logic         spawn_ready;
    logic         game_over;
    logic         timeout_err;
    logic         restart;

    // The sequencer is the slave; lock logic, evaluator and spawner together form the master.
    modport slave (
        input  lock_valid, board_in, lc_output, lc_done, spawn_ready, restart,
        output lock_ready, lc_start, lc_input, board_out, lines_total, lines_last,
               level, drop_interval, spawn_valid, game_over, timeout_err
    );

    modport master (
        output lock_valid, board_in, lc_output, lc_done, spawn_ready, restart,
        input  lock_ready, lc_start, lc_input, board_out, lines_total, lines_last,
               level, drop_interval, spawn_valid, game_over, timeout_err
    );
endinterface

// File: rtl/lineclear_sequencer.sv
// Sequences one lineclear evaluation per locked piece, then updates the
// line/level/gravity counters, checks for top-out and hands off to the spawner.
module lineclear_sequencer #(
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15,
    parameter int BASE_DROP       = 48,
    parameter int DROP_STEP       = 3,
    parameter int MIN_DROP        = 3,
    parameter int TOP_ROWS        = 2,
    parameter int TIMEOUT         = 255
) (
    input logic                  clk,
    input logic                  reset,
    lineclear_sequencer_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_START, S_WAIT, S_COMMIT, S_UPDATE, S_CHECK, S_SPAWN, S_OVER
    } state_t;

    state_t       r_state;
    logic [199:0] r_lc_input;
    logic [199:0] r_board_out;
    logic         r_lock_ready;
    logic         r_lc_start;
    logic         r_spawn_valid;
    logic         r_game_over;
    logic         r_timeout_err;
    logic [15:0]  r_lines_total;
    logic [2:0]   r_lines_last;
    logic [2:0]   r_full_rows;
    logic [3:0]   r_level;
    logic [5:0]   r_drop;
    logic [WD_W-1:0] r_wdog;

    logic [4:0]   w_full_cnt;
    logic [2:0]   w_full_clamped;
    logic [16:0]  w_sum;
    logic [15:0]  w_total_new;
    logic [15:0]  w_level_raw;
    logic [3:0]   w_level_new;
    logic [7:0]   w_step;
    logic [5:0]   w_drop_new;
    logic         w_top_hit;

    // Next counter values are computed from the committed line count so UPDATE is a single cycle.
    always_comb begin
        w_full_cnt = '0;
        for (int r = 0; r < 20; r++) begin
            if (&bus.board_in[r*10 +: 10]) w_full_cnt = w_full_cnt + 5'd1;
        end
        w_full_clamped = (w_full_cnt > 5'd4) ? 3'd4 : w_full_cnt[2:0];
        w_sum       = {1'b0, r_lines_total} + {14'd0, r_lines_last};
        w_total_new = w_sum[16] ? 16'hFFFF : w_sum[15:0];
        w_level_raw = w_total_new / 16'(LINES_PER_LEVEL);
        w_level_new = (w_level_raw > 16'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : w_level_raw[3:0];
        w_step      = {4'd0, w_level_new} * 8'(DROP_STEP);
        // Clamp before subtracting so the interval never wraps below the floor.
        w_drop_new  = ({1'b0, w_step} + 9'(MIN_DROP) >= 9'(BASE_DROP))
                      ? 6'(MIN_DROP) : 6'(8'(BASE_DROP) - w_step);
        w_top_hit   = |r_board_out[TOP_ROWS*10-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_lc_input    <= '0;
            r_board_out   <= '0;
            r_lock_ready  <= 1'b1;
            r_lc_start    <= 1'b0;
            r_spawn_valid <= 1'b0;
            r_game_over   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_lines_total <= '0;
            r_lines_last  <= '0;
            r_full_rows   <= '0;
            r_level       <= '0;
            r_drop        <= 6'(BASE_DROP);
            r_wdog        <= '0;
        end else if (bus.restart) begin
            r_state       <= S_IDLE;
            r_board_out   <= '0;
            r_lock_ready  <= 1'b1;
            r_lc_start    <= 1'b0;
            r_spawn_valid <= 1'b0;
            r_game_over   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_lines_total <= '0;
            r_lines_last  <= '0;
            r_level       <= '0;
            r_drop        <= 6'(BASE_DROP);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.lock_valid && r_lock_ready) begin
                        r_lc_input   <= bus.board_in;
                        r_full_rows  <= w_full_clamped;
                        r_lock_ready <= 1'b0;
                        r_state      <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_wdog     <= '0;
                    r_lc_start <= 1'b1;
                    r_state    <= S_START;
                end
                S_START: begin
                    r_lc_start <= 1'b0;
                    r_state    <= S_WAIT;
                end
                // Completion is tested first so a done arriving on the last watchdog cycle still commits.
                S_WAIT: begin
                    if (bus.lc_done) begin
                        r_board_out <= bus.lc_output;
                        r_state     <= S_COMMIT;
                    end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
                        r_wdog        <= r_wdog + 1'b1;
                        r_timeout_err <= 1'b1;
                        r_lines_last  <= '0;
                        r_state       <= S_CHECK;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_lines_last <= r_full_rows;
                    r_state      <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_lines_total <= w_total_new;
                    r_level       <= w_level_new;
                    r_drop        <= w_drop_new;
                    r_state       <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_top_hit) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_OVER;
                    end else begin
                        r_spawn_valid <= 1'b1;
                        r_state       <= S_SPAWN;
                    end
                end
                S_SPAWN: begin
                    if (bus.spawn_ready) begin
                        r_spawn_valid <= 1'b0;
                        r_lock_ready  <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                S_OVER:  r_state <= S_OVER;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.lock_ready    = r_lock_ready;
    assign bus.lc_start      = r_lc_start;
    assign bus.lc_input      = r_lc_input;
    assign bus.board_out     = r_board_out;
    assign bus.lines_total   = r_lines_total;
    assign bus.lines_last    = r_lines_last;
    assign bus.level         = r_level;
    assign bus.drop_interval = r_drop;
    assign bus.spawn_valid   = r_spawn_valid;
    assign bus.game_over     = r_game_over;
    assign bus.timeout_err   = r_timeout_err;
endmodule

// File: tb/tb_lineclear_sequencer.sv
// Randomized bench for lineclear_sequencer: a row-queue model of the evaluator
// and counter rules supplies every expected value.
module tb_lineclear_sequencer;
    localparam int TIMEOUT = 255;

    logic clk;
    logic reset;
    lineclear_sequencer_if bus ();

    lineclear_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    int totalChecks = 0;
    int badChecks   = 0;

    int mTotal, mLevel, mDrop, mLast;
    logic [199:0] mBoard;

    int rStartLat, rSpawnLat;
    bit rStartStuck, rOver, rHung, rTerrEarly, rTerrLate;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("[TB] FAIL global_timeout got=running want=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    // Board after the evaluator: full rows removed, survivors packed against the floor.
    function automatic logic [199:0] clear_board(input logic [199:0] b);
        logic [9:0] kept[$];
        logic [199:0] res;
        res = '0;
        for (int r = 0; r < 20; r++)
            if (b[r*10 +: 10] != 10'h3FF) kept.push_back(b[r*10 +: 10]);
        for (int i = 0; i < kept.size(); i++)
            res[(20 - kept.size() + i)*10 +: 10] = kept[i];
        return res;
    endfunction

    function automatic int count_full(input logic [199:0] b);
        int n;
        n = 0;
        for (int r = 0; r < 20; r++) if (b[r*10 +: 10] == 10'h3FF) n++;
        return n;
    endfunction

    function automatic logic [199:0] rand_board(input int nFull);
        logic [199:0] b;
        logic [9:0] row;
        b = '0;
        for (int r = 10; r < 20; r++) begin
            if (r >= 20 - nFull) row = '1;
            else begin
                row = 10'($urandom);
                row[$urandom_range(0, 9)] = 1'b0;
            end
            b[r*10 +: 10] = row;
        end
        return b;
    endfunction

    task automatic model_restart();
        mTotal = 0; mLevel = 0; mDrop = 48; mLast = 0; mBoard = '0;
    endtask

    task automatic model_commit(input logic [199:0] brd, input logic [199:0] lcOut);
        mLast  = (count_full(brd) > 4) ? 4 : count_full(brd);
        mTotal = (mTotal + mLast > 65535) ? 65535 : mTotal + mLast;
        mLevel = (mTotal / 10 > 15) ? 15 : mTotal / 10;
        mDrop  = 48 - 3 * mLevel;
        if (mDrop < 3) mDrop = 3;
        mBoard = lcOut;
    endtask

    task automatic pulse_restart();
        @(negedge clk); bus.restart = 1'b1;
        @(negedge clk); bus.restart = 1'b0;
        model_restart();
    endtask

    // Drives one piece through accept, evaluation and spawn; a negative doneDelay withholds lc_done.
    task automatic do_piece(input logic [199:0] brd, input logic [199:0] lcOut,
                            input int doneDelay, input int readyDelay);
        int t;
        rStartLat = -1; rSpawnLat = -1; rStartStuck = 0; rOver = 0; rHung = 0;
        rTerrEarly = 0; rTerrLate = 0;
        t = 0;
        while (!bus.lock_ready && t < 50) begin @(negedge clk); t++; end
        if (!bus.lock_ready) begin rHung = 1; return; end
        bus.board_in = brd; bus.lock_valid = 1'b1;
        @(negedge clk); bus.lock_valid = 1'b0; t = 1;
        while (!bus.lc_start && t < 10) begin @(negedge clk); t++; end
        if (!bus.lc_start) begin rHung = 1; return; end
        rStartLat = t;
        bus.lc_output = lcOut;
        @(negedge clk);
        rStartStuck = bus.lc_start;
        if (doneDelay >= 0) begin
            repeat (doneDelay) @(negedge clk);
            bus.lc_done = 1'b1;
            @(negedge clk); bus.lc_done = 1'b0;
        end else begin
            repeat (TIMEOUT - 1) @(negedge clk);
            rTerrEarly = bus.timeout_err;
            @(negedge clk);
            rTerrLate = bus.timeout_err;
        end
        t = 1;
        while (!bus.spawn_valid && !bus.game_over && t < 20) begin @(negedge clk); t++; end
        if (bus.game_over) begin rOver = 1; return; end
        if (!bus.spawn_valid) begin rHung = 1; return; end
        rSpawnLat = t;
        repeat (readyDelay) @(negedge clk);
        bus.spawn_ready = 1'b1;
        @(negedge clk); bus.spawn_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3 reset = 1'b0;
        #20;
        totalChecks++;
        if ({bus.lock_ready, bus.lc_start, bus.spawn_valid, bus.game_over, bus.timeout_err,
             bus.lines_last, bus.level, bus.drop_interval, bus.lines_total}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 6'd48, 16'd0}) begin
            badChecks++;
            $display("[TB] FAIL reset_scalars got=%b/%0d/%0d want=1/0/48", bus.lock_ready, bus.level, bus.drop_interval);
        end
        totalChecks++;
        if ({bus.board_out, bus.lc_input} !== 400'd0) begin
            badChecks++;
            $display("[TB] FAIL reset_boards got=%h want=0", bus.board_out);
        end
        @(negedge clk); reset = 1'b1;
        model_restart();
    endtask

    task automatic test_single_line();
        logic [199:0] brd, lcOut;
        brd = '0;
        brd[199:190] = '1;
        brd[180] = 1'b1;
        lcOut = clear_board(brd);
        do_piece(brd, lcOut, 3, 1);
        model_commit(brd, lcOut);
        totalChecks++;
        if (rHung || rOver) begin badChecks++; $display("[TB] FAIL single_flow got=hung%0d/over%0d want=0/0", rHung, rOver); end
        totalChecks++;
        if (rStartLat !== 2) begin badChecks++; $display("[TB] FAIL single_start_lat got=%0d want=2", rStartLat); end
        totalChecks++;
        if (rStartStuck !== 1'b0) begin badChecks++; $display("[TB] FAIL single_start_width got=%b want=0", rStartStuck); end
        totalChecks++;
        if (rSpawnLat !== 4) begin badChecks++; $display("[TB] FAIL single_spawn_lat got=%0d want=4", rSpawnLat); end
        totalChecks++;
        if (bus.lc_input !== brd) begin badChecks++; $display("[TB] FAIL single_lc_input got=%h want=%h", bus.lc_input, brd); end
        totalChecks++;
        if (bus.lines_last !== 3'd1 || bus.lines_total !== 16'd1) begin
            badChecks++; $display("[TB] FAIL single_lines got=%0d/%0d want=1/1", bus.lines_last, bus.lines_total);
        end
        totalChecks++;
        if (bus.board_out !== mBoard) begin badChecks++; $display("[TB] FAIL single_board got=%h want=%h", bus.board_out, mBoard); end
        totalChecks++;
        if (bus.lock_ready !== 1'b1 || bus.spawn_valid !== 1'b0) begin
            badChecks++; $display("[TB] FAIL single_handoff got=%b/%b want=1/0", bus.lock_ready, bus.spawn_valid);
        end
    endtask

    task automatic test_tetris_level();
        logic [199:0] brd;
        pulse_restart();
        for (int i = 0; i < 9; i++) begin
            brd = rand_board(1);
            do_piece(brd, clear_board(brd), $urandom_range(0, 6), $urandom_range(0, 2));
            model_commit(brd, clear_board(brd));
            totalChecks++;
            if (rHung || bus.lines_total !== 16'(mTotal)) begin
                badChecks++; $display("[TB] FAIL tetris_single%0d got=%0d want=%0d", i, bus.lines_total, mTotal);
            end
        end
        brd = '0;
        brd[199:160] = '1;
        brd[150] = 1'b1;
        do_piece(brd, clear_board(brd), 2, 0);
        model_commit(brd, clear_board(brd));
        totalChecks++;
        if ({bus.lines_last, bus.lines_total, bus.level, bus.drop_interval} !== {3'd4, 16'd13, 4'd1, 6'd45}) begin
            badChecks++;
            $display("[TB] FAIL tetris_counters got=%0d/%0d/%0d/%0d want=4/13/1/45",
                     bus.lines_last, bus.lines_total, bus.level, bus.drop_interval);
        end
    endtask

    task automatic test_saturation();
        logic [199:0] brd;
        int n;
        n = 0;
        while (mTotal < 613 && n < 400) begin
            brd = rand_board($urandom_range(2, 6));
            do_piece(brd, clear_board(brd), $urandom_range(0, 10), $urandom_range(0, 3));
            model_commit(brd, clear_board(brd));
            n++;
            totalChecks++;
            if (rHung || {bus.lines_last, bus.lines_total, bus.level, bus.drop_interval}
                         !== {3'(mLast), 16'(mTotal), 4'(mLevel), 6'(mDrop)}) begin
                badChecks++;
                $display("[TB] FAIL sat_piece%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", n,
                         bus.lines_last, bus.lines_total, bus.level, bus.drop_interval, mLast, mTotal, mLevel, mDrop);
            end
        end
        totalChecks++;
        if (bus.level !== 4'd15 || bus.drop_interval !== 6'd3) begin
            badChecks++; $display("[TB] FAIL sat_final got=%0d/%0d want=15/3", bus.level, bus.drop_interval);
        end
    endtask

    task automatic test_topout();
        logic [199:0] brd, lcOut;
        bit leaked;
        brd = rand_board(1);
        lcOut = clear_board(brd);
        lcOut[15] = 1'b1;
        do_piece(brd, lcOut, 1, 0);
        model_commit(brd, lcOut);
        totalChecks++;
        if (!rOver || bus.game_over !== 1'b1 || bus.spawn_valid !== 1'b0) begin
            badChecks++; $display("[TB] FAIL topout_flag got=%b/%b want=1/0", bus.game_over, bus.spawn_valid);
        end
        totalChecks++;
        if (bus.board_out !== mBoard) begin badChecks++; $display("[TB] FAIL topout_board got=%h want=%h", bus.board_out, mBoard); end
        leaked = 0;
        bus.board_in = rand_board(2);
        bus.lock_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.lock_ready || bus.lc_start || bus.spawn_valid) leaked = 1;
        end
        bus.lock_valid = 1'b0;
        totalChecks++;
        if (leaked) begin badChecks++; $display("[TB] FAIL topout_locked got=accepted want=ignored"); end
        pulse_restart();
        totalChecks++;
        if ({bus.lock_ready, bus.game_over, bus.drop_interval, bus.lines_total} !== {1'b1, 1'b0, 6'd48, 16'd0}) begin
            badChecks++; $display("[TB] FAIL restart_counters got=%b/%b/%0d want=1/0/48", bus.lock_ready, bus.game_over, bus.drop_interval);
        end
        totalChecks++;
        if (bus.board_out !== 200'd0) begin badChecks++; $display("[TB] FAIL restart_board got=%h want=0", bus.board_out); end
    endtask

    task automatic test_watchdog();
        logic [199:0] brd;
        int prevTotal;
        brd = rand_board(2);
        do_piece(brd, clear_board(brd), 0, 0);
        model_commit(brd, clear_board(brd));
        prevTotal = mTotal;
        brd = rand_board(3);
        do_piece(brd, ~mBoard, -1, 1);
        mLast = 0;
        totalChecks++;
        if (rTerrEarly !== 1'b0 || rTerrLate !== 1'b1) begin
            badChecks++; $display("[TB] FAIL wdog_timing got=%b%b want=01", rTerrEarly, rTerrLate);
        end
        totalChecks++;
        if (rHung || rOver || bus.timeout_err !== 1'b1) begin
            badChecks++; $display("[TB] FAIL wdog_spawn got=hung%0d/err%b want=0/1", rHung, bus.timeout_err);
        end
        totalChecks++;
        if (bus.board_out !== mBoard) begin badChecks++; $display("[TB] FAIL wdog_board got=%h want=%h", bus.board_out, mBoard); end
        totalChecks++;
        if (bus.lines_last !== 3'd0 || bus.lines_total !== 16'(prevTotal)) begin
            badChecks++; $display("[TB] FAIL wdog_lines got=%0d/%0d want=0/%0d", bus.lines_last, bus.lines_total, prevTotal);
        end
    endtask

    task automatic test_done_at_limit();
        logic [199:0] brd;
        pulse_restart();
        brd = rand_board(2);
        do_piece(brd, clear_board(brd), TIMEOUT - 1, 0);
        model_commit(brd, clear_board(brd));
        totalChecks++;
        if (rHung || bus.timeout_err !== 1'b0 || rSpawnLat !== 4) begin
            badChecks++; $display("[TB] FAIL limit_done got=err%b/lat%0d want=0/4", bus.timeout_err, rSpawnLat);
        end
        totalChecks++;
        if (bus.board_out !== mBoard || bus.lines_last !== 3'(mLast)) begin
            badChecks++; $display("[TB] FAIL limit_commit got=%0d want=%0d", bus.lines_last, mLast);
        end
    endtask

    task automatic test_back_to_back();
        logic [199:0] brd;
        for (int i = 0; i < 8; i++) begin
            brd = rand_board($urandom_range(0, 5));
            do_piece(brd, clear_board(brd), 0, 0);
            model_commit(brd, clear_board(brd));
            totalChecks++;
            if (rStartLat !== 2 || rSpawnLat !== 4 || bus.board_out !== mBoard ||
                {bus.lines_last, bus.lines_total, bus.level, bus.drop_interval}
                !== {3'(mLast), 16'(mTotal), 4'(mLevel), 6'(mDrop)}) begin
                badChecks++;
                $display("[TB] FAIL b2b_piece%0d got=%0d/%0d/lat%0d,%0d want=%0d/%0d/lat2,4", i,
                         bus.lines_last, bus.lines_total, rStartLat, rSpawnLat, mLast, mTotal);
            end
        end
    endtask

    task automatic test_restart_mid_wait();
        logic [199:0] brd;
        brd = rand_board(1);
        do_piece(brd, clear_board(brd), 0, 0);
        model_commit(brd, clear_board(brd));
        bus.board_in = rand_board(2);
        bus.lock_valid = 1'b1;
        @(negedge clk); bus.lock_valid = 1'b0;
        repeat (4) @(negedge clk);
        bus.restart = 1'b1;
        @(negedge clk); bus.restart = 1'b0;
        model_restart();
        bus.lc_output = ~200'd0;
        bus.lc_done = 1'b1;
        @(negedge clk); bus.lc_done = 1'b0;
        @(negedge clk);
        totalChecks++;
        if (bus.board_out !== 200'd0 || bus.lines_total !== 16'd0) begin
            badChecks++; $display("[TB] FAIL rstwait_board got=%h want=0", bus.board_out);
        end
        totalChecks++;
        if ({bus.lock_ready, bus.lc_start, bus.spawn_valid, bus.game_over} !== 4'b1000) begin
            badChecks++; $display("[TB] FAIL rstwait_idle got=%b want=1000", {bus.lock_ready, bus.lc_start, bus.spawn_valid, bus.game_over});
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [199:0] brd;
        brd = rand_board(2);
        do_piece(brd, clear_board(brd), 0, 0);
        model_commit(brd, clear_board(brd));
        bus.board_in = rand_board(1);
        bus.lock_valid = 1'b1;
        @(negedge clk); bus.lock_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        totalChecks++;
        if ({bus.lock_ready, bus.lc_start, bus.spawn_valid, bus.game_over, bus.timeout_err,
             bus.lines_last, bus.level, bus.drop_interval, bus.lines_total}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 6'd48, 16'd0}) begin
            badChecks++; $display("[TB] FAIL rstmid_scalars got=%b/%0d/%0d want=1/48/0", bus.lock_ready, bus.drop_interval, bus.lines_total);
        end
        totalChecks++;
        if ({bus.board_out, bus.lc_input} !== 400'd0) begin
            badChecks++; $display("[TB] FAIL rstmid_boards got=%h want=0", bus.board_out);
        end
        @(negedge clk); reset = 1'b1;
        model_restart();
        brd = rand_board(3);
        do_piece(brd, clear_board(brd), 1, 0);
        model_commit(brd, clear_board(brd));
        totalChecks++;
        if (rHung || bus.lines_total !== 16'(mTotal) || bus.board_out !== mBoard) begin
            badChecks++; $display("[TB] FAIL rstmid_resume got=%0d want=%0d", bus.lines_total, mTotal);
        end
    endtask

    initial begin
        bus.lock_valid  = 1'b0;
        bus.board_in    = '0;
        bus.lc_output   = '0;
        bus.lc_done     = 1'b0;
        bus.spawn_ready = 1'b0;
        bus.restart     = 1'b0;
        model_restart();
        test_reset();
        test_single_line();
        test_tetris_level();
        test_saturation();
        test_topout();
        test_watchdog();
        test_done_at_limit();
        test_back_to_back();
        test_restart_mid_wait();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule
